// File: rtl/sata_txfis_regh2d.sv
// SATA register host-to-device FIS transmitter.
// Streams the 5-word FIS to the link and resends it on failure or timeout.
module sata_txfis_regh2d #(
  parameter bit OPT_LITTLE_ENDIAN = 1'b0,
  parameter int MAX_RETRIES       = 3,
  parameter int LGTIMEOUT         = 20
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [7:0]  i_command,
  input  logic [15:0] i_features,
  input  logic [47:0] i_lba,
  input  logic [7:0]  i_device,
  input  logic [15:0] i_count,
  input  logic [7:0]  i_icc,
  input  logic [7:0]  i_control,
  input  logic        i_cbit,
  input  logic [3:0]  i_pmport,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_last,
  input  logic        i_success,
  input  logic        i_failed,
  input  logic        i_link_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [1:0]  o_retries
);

  typedef enum logic [1:0] {
    IDLE, WAIT_LINK, SEND, WAIT_RESP
  } state_t;

  localparam logic [1:0] MAXR = 2'(MAX_RETRIES);
  // Timer starts at 0, so this value ends the 2^LGTIMEOUT-1 cycle window
  localparam logic [LGTIMEOUT-1:0] TLIM =
    {{(LGTIMEOUT-1){1'b1}}, 1'b0};

  state_t state;

  logic [7:0]  r_command;
  logic [15:0] r_features;
  logic [47:0] r_lba;
  logic [7:0]  r_device;
  logic [15:0] r_count;
  logic [7:0]  r_icc;
  logic [7:0]  r_control;
  logic        r_cbit;
  logic [3:0]  r_pmport;

  logic [2:0]           idx;
  logic [LGTIMEOUT-1:0] timer;
  logic                 timeout;
  logic                 hs;

  assign timeout = (timer == TLIM);
  assign hs      = m_valid && m_ready;

  function automatic logic [31:0] fis_word(input logic [2:0] n);
    logic [7:0] b0, b1, b2, b3;
    b0 = 8'h00;
    b1 = 8'h00;
    b2 = 8'h00;
    b3 = 8'h00;
    case (n)
      3'd0: {b0, b1, b2, b3} =
        {8'h27, r_cbit, 3'b000, r_pmport,
         r_command, r_features[7:0]};
      3'd1: {b0, b1, b2, b3} =
        {r_lba[7:0], r_lba[15:8],
         r_lba[23:16], r_device};
      3'd2: {b0, b1, b2, b3} =
        {r_lba[31:24], r_lba[39:32],
         r_lba[47:40], r_features[15:8]};
      3'd3: {b0, b1, b2, b3} =
        {r_count[7:0], r_count[15:8],
         r_icc, r_control};
      default: ;
    endcase
    if (OPT_LITTLE_ENDIAN)
      return {b3, b2, b1, b0};
    return {b0, b1, b2, b3};
  endfunction

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state       <= IDLE;
      o_cmd_ready <= 1'b0;
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
      m_data      <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_retries   <= 2'd0;
      idx         <= 3'd0;
      timer       <= '0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_cmd_valid && o_cmd_ready) begin
            r_command   <= i_command;
            r_features  <= i_features;
            r_lba       <= i_lba;
            r_device    <= i_device;
            r_count     <= i_count;
            r_icc       <= i_icc;
            r_control   <= i_control;
            r_cbit      <= i_cbit;
            r_pmport    <= i_pmport;
            o_retries   <= 2'd0;
            o_cmd_ready <= 1'b0;
            o_busy      <= 1'b1;
            state       <= WAIT_LINK;
          end else begin
            o_cmd_ready <= 1'b1;
          end
        end
        WAIT_LINK: begin
          if (i_link_ready) begin
            idx     <= 3'd0;
            m_valid <= 1'b1;
            m_last  <= 1'b0;
            m_data  <= fis_word(3'd0);
            state   <= SEND;
          end
        end
        SEND: begin
          if (hs) begin
            if (idx == 3'd4) begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              timer   <= '0;
              state   <= WAIT_RESP;
            end else begin
              idx    <= idx + 3'd1;
              m_data <= fis_word(idx + 3'd1);
              m_last <= (idx == 3'd3);
            end
          end
        end
        WAIT_RESP: begin
          if (i_success) begin
            o_done      <= 1'b1;
            o_busy      <= 1'b0;
            o_cmd_ready <= 1'b1;
            state       <= IDLE;
          end else if (i_failed || timeout) begin
            if (o_retries < MAXR) begin
              o_retries <= o_retries + 2'd1;
              state     <= WAIT_LINK;
            end else begin
              o_err       <= 1'b1;
              o_busy      <= 1'b0;
              o_cmd_ready <= 1'b1;
              state       <= IDLE;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sata_txfis_regh2d.sv
// Directed bench for sata_txfis_regh2d.
// Link side is modelled by a handshake recorder and per-scenario tasks.
module tb_sata_txfis_regh2d;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_cmd_valid = 1'b0;
  logic        o_cmd_ready;
  logic [7:0]  i_command = '0;
  logic [15:0] i_features = '0;
  logic [47:0] i_lba = '0;
  logic [7:0]  i_device = '0;
  logic [15:0] i_count = '0;
  logic [7:0]  i_icc = '0;
  logic [7:0]  i_control = '0;
  logic        i_cbit = 1'b0;
  logic [3:0]  i_pmport = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic        m_last;
  logic        i_success = 1'b0;
  logic        i_failed = 1'b0;
  logic        i_link_ready = 1'b0;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic [1:0]  o_retries;

  sata_txfis_regh2d #(
    .OPT_LITTLE_ENDIAN(1'b0),
    .MAX_RETRIES(3),
    .LGTIMEOUT(4)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_command(i_command), .i_features(i_features),
    .i_lba(i_lba), .i_device(i_device), .i_count(i_count),
    .i_icc(i_icc), .i_control(i_control),
    .i_cbit(i_cbit), .i_pmport(i_pmport),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last),
    .i_success(i_success), .i_failed(i_failed),
    .i_link_ready(i_link_ready),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_retries(o_retries)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad = 0;

  int          hs_cnt = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          stab_bad = 0;
  logic [31:0] hs_data [128];
  logic        hs_last [128];
  logic        pend = 1'b0;
  logic [31:0] pend_data = '0;

  // Link-side recorder: handshakes, pulses, and stalled-word stability
  always @(posedge i_clk) begin
    if (pend && (!m_valid || m_data != pend_data))
      stab_bad <= stab_bad + 1;
    pend      <= i_reset_n && m_valid && !m_ready;
    pend_data <= m_data;
    if (i_reset_n && m_valid && m_ready) begin
      hs_data[hs_cnt[6:0]] <= m_data;
      hs_last[hs_cnt[6:0]] <= m_last;
      hs_cnt <= hs_cnt + 1;
    end
    if (o_done) done_cnt <= done_cnt + 1;
    if (o_err)  err_cnt  <= err_cnt + 1;
  end

  logic [31:0] exp_a [5] = '{32'h27802500, 32'h78563440,
                             32'h12000000, 32'h08000000,
                             32'h00000000};
  logic [31:0] exp_b [5] = '{32'h278535B2, 32'h060504E0,
                             32'h030201A1, 32'h22113308,
                             32'h00000000};

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_a();
    i_command = 8'h25; i_features = 16'h0000;
    i_lba = 48'h0000_1234_5678; i_device = 8'h40;
    i_count = 16'h0008; i_icc = 8'h00;
    i_control = 8'h00; i_cbit = 1'b1; i_pmport = 4'h0;
  endtask

  task automatic set_b();
    i_command = 8'h35; i_features = 16'hA1B2;
    i_lba = 48'h0102_0304_0506; i_device = 8'hE0;
    i_count = 16'h1122; i_icc = 8'h33;
    i_control = 8'h08; i_cbit = 1'b1; i_pmport = 4'h5;
  endtask

  task automatic scramble();
    i_command = 8'hFF; i_features = 16'hFFFF;
    i_lba = '1; i_device = 8'hFF; i_count = 16'hFFFF;
    i_icc = 8'hFF; i_control = 8'hFF;
    i_cbit = 1'b0; i_pmport = 4'hF;
  endtask

  // Present the staged command until accepted, then garble the inputs
  task automatic accept();
    int n = 0;
    while (!o_cmd_ready && n < 50) begin
      tick();
      n++;
    end
    total++;
    if (o_cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL accept_wait: ready=%b want 1", o_cmd_ready);
    end
    i_cmd_valid = 1'b1;
    tick();
    i_cmd_valid = 1'b0;
    scramble();
  endtask

  task automatic wait_hs(input int target, input int limit,
                         input bit rnd, input string tag);
    int n = 0;
    while (hs_cnt < target && n < limit) begin
      if (rnd) m_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    total++;
    if (hs_cnt !== target) begin
      bad++;
      $display("FAIL %s: handshakes=%0d want %0d",
               tag, hs_cnt, target);
    end
  endtask

  task automatic respond(input logic s, input logic f);
    i_success = s;
    i_failed  = f;
    tick();
    i_success = 1'b0;
    i_failed  = 1'b0;
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    tick(); tick(); tick();
    total++;
    if ({m_valid, m_last, o_busy, o_done, o_err} !== 5'b0) begin
      bad++;
      $display("FAIL rst_outs: got %b want 00000",
               {m_valid, m_last, o_busy, o_done, o_err});
    end
    total++;
    if ({o_cmd_ready, o_retries} !== 3'b000) begin
      bad++;
      $display("FAIL rst_ready: got %b want 000",
               {o_cmd_ready, o_retries});
    end
    i_reset_n = 1'b1;
    tick();
    total++;
    if (o_cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_release: ready=%b want 1", o_cmd_ready);
    end
  endtask

  task automatic test_basic();
    int base = hs_cnt;
    int d0 = done_cnt;
    m_ready = 1'b1;
    i_link_ready = 1'b1;
    set_a();
    accept();
    i_success = 1'b1;
    total++;
    if (m_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_lat1: m_valid=%b want 0", m_valid);
    end
    tick();
    i_success = 1'b0;
    total++;
    if (m_valid !== 1'b1 || m_data !== exp_a[0]) begin
      bad++;
      $display("FAIL basic_lat2: valid=%b data=%h want 1 %h",
               m_valid, m_data, exp_a[0]);
    end
    wait_hs(base + 5, 40, 1'b0, "basic_hs");
    for (int i = 0; i < 5; i++) begin
      total++;
      if (hs_data[base+i] !== exp_a[i] ||
          hs_last[base+i] !== (i == 4)) begin
        bad++;
        $display("FAIL basic_w%0d: got %h/%b want %h/%b", i,
                 hs_data[base+i], hs_last[base+i],
                 exp_a[i], i == 4);
      end
    end
    total++;
    if (done_cnt !== d0) begin
      bad++;
      $display("FAIL basic_early_success: done=%0d want %0d",
               done_cnt - d0, 0);
    end
    respond(1'b1, 1'b0);
    total++;
    if (o_done !== 1'b1) begin
      bad++;
      $display("FAIL basic_done: o_done=%b want 1", o_done);
    end
    tick();
    total++;
    if ({o_done, o_busy, o_cmd_ready} !== 3'b001 ||
        done_cnt - d0 !== 1) begin
      bad++;
      $display("FAIL basic_idle: got %b cnt=%0d want 001 cnt=1",
               {o_done, o_busy, o_cmd_ready}, done_cnt - d0);
    end
  endtask

  task automatic test_backpressure();
    int base = hs_cnt;
    int d0 = done_cnt;
    int s0 = stab_bad;
    m_ready = 1'b0;
    set_a();
    accept();
    wait_hs(base + 5, 300, 1'b1, "bp_hs");
    m_ready = 1'b1;
    respond(1'b1, 1'b0);
    tick(); tick(); tick();
    total++;
    if (hs_cnt - base !== 5) begin
      bad++;
      $display("FAIL bp_count: got %0d want 5", hs_cnt - base);
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (hs_data[base+i] !== exp_a[i]) begin
        bad++;
        $display("FAIL bp_w%0d: got %h want %h", i,
                 hs_data[base+i], exp_a[i]);
      end
    end
    total++;
    if (stab_bad - s0 !== 0) begin
      bad++;
      $display("FAIL bp_stable: changes=%0d want 0", stab_bad - s0);
    end
    total++;
    if (done_cnt - d0 !== 1) begin
      bad++;
      $display("FAIL bp_done: got %0d want 1", done_cnt - d0);
    end
  endtask

  task automatic test_retry();
    int base = hs_cnt;
    int d0 = done_cnt;
    int e0 = err_cnt;
    m_ready = 1'b1;
    set_b();
    accept();
    for (int k = 0; k < 3; k++) begin
      wait_hs(base + 5 * (k + 1), 40, 1'b0, "retry_hs");
      respond(k == 2, k < 2);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (hs_data[base+5*k+i] !== exp_b[i] ||
            hs_last[base+5*k+i] !== (i == 4)) begin
          bad++;
          $display("FAIL retry_s%0d_w%0d: got %h/%b want %h/%b",
                   k, i, hs_data[base+5*k+i],
                   hs_last[base+5*k+i], exp_b[i], i == 4);
        end
      end
    end
    total++;
    if (o_retries !== 2'd2 || done_cnt - d0 !== 1 ||
        err_cnt - e0 !== 0) begin
      bad++;
      $display("FAIL retry_status: r=%0d d=%0d e=%0d want 2 1 0",
               o_retries, done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_exhaust();
    int base = hs_cnt;
    int d0 = done_cnt;
    int e0 = err_cnt;
    m_ready = 1'b1;
    set_b();
    accept();
    total++;
    if (o_retries !== 2'd0) begin
      bad++;
      $display("FAIL exh_clear: retries=%0d want 0", o_retries);
    end
    for (int k = 0; k < 4; k++) begin
      wait_hs(base + 5 * (k + 1), 40, 1'b0, "exh_hs");
      respond(1'b0, 1'b1);
    end
    total++;
    if (o_err !== 1'b1) begin
      bad++;
      $display("FAIL exh_err: o_err=%b want 1", o_err);
    end
    tick(); tick();
    total++;
    if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0 ||
        hs_cnt - base !== 20) begin
      bad++;
      $display("FAIL exh_counts: e=%0d d=%0d hs=%0d want 1 0 20",
               err_cnt - e0, done_cnt - d0, hs_cnt - base);
    end
    total++;
    if (o_retries !== 2'd3 || o_busy !== 1'b0 ||
        o_cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL exh_idle: r=%0d busy=%b rdy=%b want 3 0 1",
               o_retries, o_busy, o_cmd_ready);
    end
    total++;
    if (hs_data[base+15] !== exp_b[0]) begin
      bad++;
      $display("FAIL exh_last_w0: got %h want %h",
               hs_data[base+15], exp_b[0]);
    end
  endtask

  task automatic test_timeout();
    int base = hs_cnt;
    int d0 = done_cnt;
    int e0 = err_cnt;
    int n = 0;
    m_ready = 1'b1;
    set_a();
    accept();
    wait_hs(base + 5, 40, 1'b0, "to_hs1");
    while (!m_valid && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (n !== 16 || o_retries !== 2'd1) begin
      bad++;
      $display("FAIL to_gap: cycles=%0d r=%0d want 16 1",
               n, o_retries);
    end
    wait_hs(base + 10, 40, 1'b0, "to_hs2");
    respond(1'b1, 1'b1);
    tick();
    total++;
    if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0 ||
        o_retries !== 2'd1) begin
      bad++;
      $display("FAIL to_both: d=%0d e=%0d r=%0d want 1 0 1",
               done_cnt - d0, err_cnt - e0, o_retries);
    end
  endtask

  task automatic test_reset_mid();
    int base = hs_cnt;
    int b2;
    m_ready = 1'b1;
    set_b();
    accept();
    wait_hs(base + 3, 40, 1'b0, "mid_hs");
    i_reset_n = 1'b0;
    m_ready = 1'b0;
    tick();
    total++;
    if ({m_valid, o_busy, o_cmd_ready} !== 3'b000) begin
      bad++;
      $display("FAIL mid_rst: got %b want 000",
               {m_valid, o_busy, o_cmd_ready});
    end
    i_reset_n = 1'b1;
    tick();
    total++;
    if (o_cmd_ready !== 1'b1 || m_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_release: rdy=%b valid=%b want 1 0",
               o_cmd_ready, m_valid);
    end
    m_ready = 1'b1;
    tick(); tick(); tick(); tick();
    total++;
    if (hs_cnt - base !== 3) begin
      bad++;
      $display("FAIL mid_no_resume: hs=%0d want 3", hs_cnt - base);
    end
    b2 = hs_cnt;
    set_b();
    accept();
    wait_hs(b2 + 5, 40, 1'b0, "mid_new_hs");
    for (int i = 0; i < 5; i++) begin
      total++;
      if (hs_data[b2+i] !== exp_b[i]) begin
        bad++;
        $display("FAIL mid_new_w%0d: got %h want %h", i,
                 hs_data[b2+i], exp_b[i]);
      end
    end
    respond(1'b1, 1'b0);
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_retry();
    test_exhaust();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
